psum_deskew_acc: RTL and testbench
==================================

# psum_deskew_acc

Downstream collector for the systolic array: takes the 19-bit `result` of every PE row and removes the one-cycle-per-row stagger the array introduces. It accumulates aligned vectors across K-tiles into wider accumulators and presents each finished output vector with a valid/ready handshake. Sits between the row of PE chains and the output buffer/writeback logic.

## Interface
- `PARTIAL_SUM_BW`, 19: width of each row result (signed).
- `ACC_BW`, 24: width of each accumulator (signed, ≥ `PARTIAL_SUM_BW`).
- `MATRIX_SIZE`, 8: number of PE rows (result lanes).
- `clk` in 1: clock; single clock domain.
- `rstn` in 1: reset, synchronous, active-low.
- `in_valid` in 1: row-0 result valid this cycle; row r's result is valid r cycles later.
- `in_first` in 1: qualifies `in_valid`; first K-tile of an output vector.
- `in_last` in 1: qualifies `in_valid`; last K-tile of an output vector.
- `RESULTS` in `MATRIX_SIZE*PARTIAL_SUM_BW`: signed row results; row 0 in the MSB slice, row `MATRIX_SIZE-1` in the LSB slice.
- `out_valid` out 1: `ACC_OUT` holds a completed vector.
- `out_ready` in 1: consumer accepts `ACC_OUT` when `out_valid && out_ready`.
- `ACC_OUT` out `MATRIX_SIZE*ACC_BW`: signed accumulated vector; same packing as `RESULTS`.
- `err_ovf` out 1: sticky; a completed vector was dropped because the output register was held.
- `err_seq` out 1: sticky; tile-sequence violation (see Operation).

## Operation
- Deskew: row r passes through a delay line of `MATRIX_SIZE-1-r` registers. Row `MATRIX_SIZE-1` is undelayed. `in_valid`/`in_first`/`in_last` pass through `MATRIX_SIZE-1` registers. All lanes arrive aligned with the delayed control bits (the "aligned vector").
- Accumulator FSM, states IDLE and ACCUM:
  - Aligned valid with first: `acc <= sext(vec)` in every lane.
  - Aligned valid without first: `acc <= acc + sext(vec)`.
  - ACCUM with first: restarts the accumulation; the partial sum is discarded and `err_seq` is set.
  - IDLE without first: treated as first; `err_seq` is set.
  - With last: go to IDLE. Otherwise go to ACCUM.
- Arithmetic: sign-extend to `ACC_BW`, two's-complement add, wrap modulo 2^`ACC_BW`, no saturation.
- Output register FSM, states EMPTY and FULL:
  - When an aligned last arrives, `acc_next` is loaded into `ACC_OUT` if the register is EMPTY or is handshaking this cycle. `out_valid` is 1 next cycle.
  - If the register is FULL and `out_ready` is 0, the new vector is dropped, `ACC_OUT` is unchanged and `err_ovf` is set.
  - A handshake with no new load goes to EMPTY.
- `in_valid` may be asserted every cycle. Tiles of consecutive vectors may be back-to-back.
- Reset mid-operation clears all delay lines, both FSMs, `acc` and the sticky errors. In-flight results are lost.

## Timing
- Reset values: `out_valid`=0, `ACC_OUT`=0, `err_ovf`=0, `err_seq`=0. All delay-line registers and `acc` are 0.
- `in_valid` with `in_last` on row 0 in cycle t: `out_valid`=1 and `ACC_OUT` updated in cycle t+`MATRIX_SIZE` (8 by default).
- `ACC_OUT` is held stable while `out_valid && !out_ready`.
- Handshake and new load in the same cycle: `out_valid` stays 1 and `ACC_OUT` takes the new value next cycle. No `err_ovf`.
- Sticky errors are set one cycle after the offending aligned cycle and are cleared only by `rstn`=0.
- No combinational path from `out_ready` to any output.

## Structure
- The shared package `sysarr_pkg` holds:
  - the default `PARTIAL_SUM_BW`/`ACC_BW`/`MATRIX_SIZE` constants (shared with the PE row);
  - the FSM state encodings (IDLE/ACCUM, EMPTY/FULL);
  - a sign-extend function.
- Sub-module `skew_delay_line` (params `WIDTH`, `DEPTH`, with `DEPTH`=0 as passthrough) is instantiated once per lane and once for the control bits. The same module is reusable by the upstream input skewer.

## Test plan
1. Reset: hold `rstn`=0 for 3 cycles with random inputs -> all outputs 0. Release -> still 0 with `in_valid`=0.
2. Single tile: `in_first`=`in_last`=1 and row r presents value r+1 in cycle t+r -> `out_valid` in t+8, lanes 1..8 (row 0 = 1). With `out_ready`=1, `out_valid` drops in t+9.
3. Three-tile accumulation: all rows give -5 in each tile (first, mid, last) -> every lane 0xFFFFF1 (-15). No errors.
4. Backpressure: `out_ready`=0 and two single-tile vectors of 7 then 9 -> `ACC_OUT` stays 7 and `err_ovf`=1. Raise `out_ready` -> 7 is accepted and `out_valid` goes to 0.
5. Simultaneous: `out_ready`=1 with back-to-back single-tile vectors 3 then 4 -> `out_valid` is 1 for two consecutive cycles with 3 then 4. `err_ovf`=0.
6. Wrap, sequence and reset:
   - 33 tiles of 262143 -> every lane -8126497 (wrapped at 24 bits).
   - A tile with no `in_first` after reset -> `err_seq`=1.
   - `rstn`=0 mid-vector -> all outputs 0 and no stale `out_valid` afterwards.

Source files
------------

// File: rtl/sysarr_pkg.sv
// Shared systolic-array definitions: default widths, FSM encodings, sign extension.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sysarr_pkg;

    // Defaults shared with the PE row so both sides agree on lane widths.
    localparam int PARTIAL_SUM_BW_DEF = 19;
    localparam int ACC_BW_DEF         = 24;
    localparam int MATRIX_SIZE_DEF    = 8;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Sign-extend the low from_bw bits of val to 64 bits. Callers truncate to
    // their own width, which keeps the helper usable for any lane/acc width.
    function automatic logic [63:0] sext64(input logic [63:0] val,
                                           input int unsigned from_bw);
        logic signed [63:0] shifted;
        shifted = signed'(val << (64 - from_bw));
        return unsigned'(shifted >>> (64 - from_bw));
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a wire.
// Latency: DEPTH cycles.
// Backpressure: none; data advances every cycle.
//
// Ports: clk, rstn (sync active-low, clears every stage), d (WIDTH in),
//        q (d delayed by DEPTH cycles).
module skew_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = clk ^ rstn;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/psum_deskew_acc.sv
// Deskews staggered PE-row results, accumulates K-tiles, presents finished vectors.
// Latency: row-0 tile with last in cycle t -> out_valid/ACC_OUT in cycle t+MATRIX_SIZE.
// Backpressure: single output register; a vector completing while it is held is dropped (err_ovf).
//
// Ports: clk, rstn (sync active-low); in_valid/in_first/in_last qualify row 0,
//        row r arrives r cycles later on RESULTS (row 0 in MSB slice);
//        out_valid/out_ready/ACC_OUT output handshake (same packing);
//        err_ovf, err_seq sticky error flags.
module psum_deskew_acc
    import sysarr_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = PARTIAL_SUM_BW_DEF,
    parameter int ACC_BW         = ACC_BW_DEF,
    parameter int MATRIX_SIZE    = MATRIX_SIZE_DEF
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               in_valid,
    input  logic                               in_first,
    input  logic                               in_last,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] RESULTS,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MATRIX_SIZE*ACC_BW-1:0]      ACC_OUT,
    output logic                               err_ovf,
    output logic                               err_seq
);

    localparam int PSB = PARTIAL_SUM_BW;

    logic [MATRIX_SIZE*PSB-1:0]    aligned;
    logic [2:0]                    ctl_q;
    logic                          al_valid, al_first, al_last;

    // Row r sits in slice MATRIX_SIZE-1-r and needs MATRIX_SIZE-1-r stages to
    // line up with the last row, which is already on time.
    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_lane
        localparam int LSB = (MATRIX_SIZE - 1 - r) * PSB;
        skew_delay_line #(
            .WIDTH (PSB),
            .DEPTH (MATRIX_SIZE - 1 - r)
        ) u_dly (
            .clk  (clk),
            .rstn (rstn),
            .d    (RESULTS[LSB +: PSB]),
            .q    (aligned[LSB +: PSB])
        );
    end

    skew_delay_line #(
        .WIDTH (3),
        .DEPTH (MATRIX_SIZE - 1)
    ) u_ctl_dly (
        .clk  (clk),
        .rstn (rstn),
        .d    ({in_valid, in_first, in_last}),
        .q    (ctl_q)
    );

    assign {al_valid, al_first, al_last} = ctl_q;

    acc_state_t                 acc_state, acc_state_nxt;
    out_state_t                 out_state, out_state_nxt;
    logic [MATRIX_SIZE*ACC_BW-1:0] acc, acc_next;
    logic                       restart, seq_viol, load, drop;

    // Accumulator FSM. A missing first while idle still starts a fresh sum,
    // and a stray first mid-vector throws the partial sum away.
    always_comb begin
        acc_state_nxt = acc_state;
        restart       = 1'b0;
        seq_viol      = 1'b0;
        if (al_valid) begin
            restart       = al_first || (acc_state == ACC_IDLE);
            seq_viol      = (al_first && (acc_state == ACC_ACCUM)) ||
                            (!al_first && (acc_state == ACC_IDLE));
            acc_state_nxt = al_last ? ACC_IDLE : ACC_ACCUM;
        end
    end

    // Per-lane sign-extend and add; wraps naturally at ACC_BW.
    always_comb begin
        acc_next = '0;
        for (int l = 0; l < MATRIX_SIZE; l++) begin
            acc_next[l*ACC_BW +: ACC_BW] =
                (restart ? '0 : acc[l*ACC_BW +: ACC_BW]) +
                ACC_BW'(sext64(64'(aligned[l*PSB +: PSB]), PSB));
        end
    end

    // Output register FSM. A concurrent handshake frees the slot for the new
    // vector in the same cycle, so back-to-back vectors stream without loss.
    always_comb begin
        out_state_nxt = out_state;
        load          = 1'b0;
        drop          = 1'b0;
        if (al_valid && al_last) begin
            if ((out_state == OUT_EMPTY) || out_ready) begin
                load          = 1'b1;
                out_state_nxt = OUT_FULL;
            end else begin
                drop = 1'b1;
            end
        end else if ((out_state == OUT_FULL) && out_ready) begin
            out_state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_state <= ACC_IDLE;
            out_state <= OUT_EMPTY;
            acc       <= '0;
            ACC_OUT   <= '0;
            err_ovf   <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            acc_state <= acc_state_nxt;
            out_state <= out_state_nxt;
            if (al_valid) acc <= acc_next;
            if (load)     ACC_OUT <= acc_next;
            if (drop)     err_ovf <= 1'b1;
            if (seq_viol) err_seq <= 1'b1;
        end
    end

    assign out_valid = (out_state == OUT_FULL);

endmodule

// File: tb/tb_psum_deskew_acc.sv
// Randomised scoreboard bench for psum_deskew_acc against an integer reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready is planned per cycle alongside the stimulus.
module tb_psum_deskew_acc;

    localparam int PSB  = 19;
    localparam int ABW  = 24;
    localparam int M    = 8;
    localparam int LAT  = M - 1;
    localparam int MAXC = 1024;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid, in_first, in_last;
    logic [M*PSB-1:0]     results;
    logic                 out_valid;
    logic                 out_ready;
    logic [M*ABW-1:0]     acc_out;
    logic                 err_ovf, err_seq;

    always #5 clk = ~clk;

    psum_deskew_acc #(
        .PARTIAL_SUM_BW (PSB),
        .ACC_BW         (ABW),
        .MATRIX_SIZE    (M)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .RESULTS   (results),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ACC_OUT   (acc_out),
        .err_ovf   (err_ovf),
        .err_seq   (err_seq)
    );

    typedef struct {
        bit             ov;
        bit             eo;
        bit             es;
        bit             flush;
        logic [M*ABW-1:0] acc;
    } exp_t;

    exp_t             exp_q[$];
    logic [M*ABW-1:0] vec_q[$];
    int               checks   = 0;
    int               failures = 0;

    // Cycle-indexed stimulus plan; tile data belongs to the cycle its row 0 is issued.
    bit p_rst_n [MAXC];
    bit p_v     [MAXC];
    bit p_f     [MAXC];
    bit p_l     [MAXC];
    bit p_rdy   [MAXC];
    int p_d     [MAXC][M];
    int pc = 0;
    int tv [M];

    // Reference model state: plain integer sums per row plus output-slot occupancy.
    bit               m_full, m_accum, m_eo, m_es;
    int               sums [M];
    logic [M*ABW-1:0] m_acc;

    function automatic int rand19();
        return int'($urandom_range(0, 524287)) - 262144;
    endfunction

    function automatic int wrap24(input longint v);
        logic signed [ABW-1:0] t;
        t = ABW'(v);
        return int'(t);
    endfunction

    task automatic chk(input string name, input logic [M*ABW-1:0] act,
                       input logic [M*ABW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic plan_cycle(input bit rst_n, input bit v, input bit f,
                              input bit l, input bit rdy);
        if (pc >= MAXC) begin
            $display("FAIL plan_overflow: pc=%0d limit=%0d", pc, MAXC);
            $fatal(1);
        end
        p_rst_n[pc] = rst_n;
        p_v[pc]     = v;
        p_f[pc]     = f;
        p_l[pc]     = l;
        p_rdy[pc]   = rdy;
        for (int r = 0; r < M; r++) p_d[pc][r] = tv[r];
        pc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) plan_cycle(1'b1, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) plan_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_const(input int v);
        for (int r = 0; r < M; r++) tv[r] = v;
    endtask

    task automatic set_rand();
        for (int r = 0; r < M; r++) tv[r] = rand19();
    endtask

    // Outcome of the clock edge that ends cycle c, expressed as the outputs
    // visible during cycle c+1.
    task automatic model_step(input int c);
        exp_t e;
        e.flush = 1'b0;
        if (!p_rst_n[c]) begin
            m_full  = 1'b0;
            m_accum = 1'b0;
            m_eo    = 1'b0;
            m_es    = 1'b0;
            m_acc   = '0;
            for (int r = 0; r < M; r++) sums[r] = 0;
            e.flush = 1'b1;
        end else begin
            int  i;
            bit  alive;
            bit  restart;
            i     = c - LAT;
            alive = (i >= 0) && p_v[i];
            // Any reset while the tile was still travelling the skew lines loses it.
            for (int x = i; x < c; x++)
                if (x >= 0 && !p_rst_n[x]) alive = 1'b0;
            if (alive) begin
                restart = p_f[i] || !m_accum;
                if (p_f[i] && m_accum)   m_es = 1'b1;
                if (!p_f[i] && !m_accum) m_es = 1'b1;
                for (int r = 0; r < M; r++)
                    sums[r] = restart ? p_d[i][r]
                                      : wrap24(longint'(sums[r]) + longint'(p_d[i][r]));
                m_accum = !p_l[i];
                if (p_l[i]) begin
                    if (!m_full || p_rdy[c]) begin
                        for (int r = 0; r < M; r++)
                            m_acc[(M-1-r)*ABW +: ABW] = ABW'(sums[r]);
                        vec_q.push_back(m_acc);
                        m_full = 1'b1;
                    end else begin
                        m_eo = 1'b1;
                    end
                end else if (m_full && p_rdy[c]) begin
                    m_full = 1'b0;
                end
            end else if (m_full && p_rdy[c]) begin
                m_full = 1'b0;
            end
        end
        e.ov  = m_full;
        e.eo  = m_eo;
        e.es  = m_es;
        e.acc = m_acc;
        exp_q.push_back(e);
    endtask

    initial begin : driver
        // Reset held 3 cycles with random traffic on the inputs.
        for (int k = 0; k < 3; k++) begin
            set_rand();
            plan_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(10, 1'b1);
        // Single tile, row r carries r+1.
        for (int r = 0; r < M; r++) tv[r] = r + 1;
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(12, 1'b1);
        // Three-tile accumulation of -5.
        set_const(-5);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        plan_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        plan_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(12, 1'b1);
        // Backpressure: 7 then 9 with the consumer stalled.
        set_const(7);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_const(9);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b0);
        idle(4, 1'b1);
        // Back-to-back vectors with a free-running consumer.
        do_reset(2);
        idle(2, 1'b1);
        set_const(3);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_const(4);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(12, 1'b1);
        // 33 tiles of the largest positive value wrap the accumulators.
        set_const(262143);
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 31; k++) plan_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        plan_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(12, 1'b1);
        // Tile without first straight after reset.
        do_reset(2);
        idle(2, 1'b1);
        set_rand();
        plan_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(12, 1'b1);
        // Reset while a vector is still in the skew lines.
        set_rand();
        plan_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        set_rand();
        plan_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        do_reset(2);
        idle(15, 1'b1);
        // Random traffic, tile flags and consumer stalls.
        for (int k = 0; k < 300; k++) begin
            set_rand();
            plan_cycle(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        idle(20, 1'b1);

        for (int c = 0; c < pc; c++) begin
            rstn      = p_rst_n[c];
            in_valid  = p_v[c];
            in_first  = p_f[c];
            in_last   = p_l[c];
            out_ready = p_rdy[c];
            for (int r = 0; r < M; r++) begin
                if (c - r >= 0 && p_v[c-r])
                    results[(M-1-r)*PSB +: PSB] = PSB'(p_d[c-r][r]);
                else
                    results[(M-1-r)*PSB +: PSB] = PSB'(rand19());
            end
            model_step(c);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        chk("vectors_outstanding", (M*ABW)'(vec_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : monitor
        exp_t             e;
        logic [M*ABW-1:0] want;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL exp_underflow @%0t: got no expectation required one", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.flush) vec_q.delete();
                chk("out_valid", (M*ABW)'(out_valid), (M*ABW)'(e.ov));
                chk("err_ovf",   (M*ABW)'(err_ovf),   (M*ABW)'(e.eo));
                chk("err_seq",   (M*ABW)'(err_seq),   (M*ABW)'(e.es));
                chk("acc_out",   acc_out,             e.acc);
                if (out_valid && out_ready) begin
                    if (vec_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_vector @%0t: got %h expected none", $time, acc_out);
                    end else begin
                        want = vec_q.pop_front();
                        chk("handshake_vector", acc_out, want);
                    end
                end
            end
        end
    end

endmodule
